// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// hazard controller (slave): ID/EX/MEM hazard sources in, stage holds/clears out.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_md;
  logic       id_mfhilo;
  logic       ex_memread;
  logic [4:0] ex_rt;
  logic       ex_md_start;
  logic       ex_md_div;
  logic       ex_br_taken;
  logic       mem_wait;
  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_clear;
  logic       idex_hold;
  logic       idex_clear;
  logic       exmem_hold;
  logic       exmem_clear;
  logic       memwb_hold;
  logic       memwb_clear;
  logic       md_busy;
  logic       md_done;

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_md, id_mfhilo,
           ex_memread, ex_rt, ex_md_start, ex_md_div, ex_br_taken, mem_wait,
    output pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
           exmem_hold, exmem_clear, memwb_hold, memwb_clear, md_busy, md_done
  );

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_md, id_mfhilo,
           ex_memread, ex_rt, ex_md_start, ex_md_div, ex_br_taken, mem_wait,
    input  pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear,
           exmem_hold, exmem_clear, memwb_hold, memwb_clear, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div occupancy stalls, branch
// flush and memory-wait freeze, plus the mult/div busy tracker.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  state_t     state, state_nx;
  logic [5:0] cnt, cnt_nx;
  logic       busy, done;
  logic       load_use, md_stall;

  logic pc_hold, ifid_hold, ifid_clear, idex_hold, idex_clear;
  logic exmem_hold, memwb_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Occupancy counter runs free of every stall/flush input; a start seen
  // while busy is dropped.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: begin
        if (hz.ex_md_start) begin
          cnt_nx   = hz.ex_md_div ? DIV_LOAD : MUL_LOAD;
          state_nx = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) begin
          state_nx = RUN;
        end else begin
          cnt_nx = cnt - 6'd1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign busy = (state == MD_BUSY);
  assign done = busy && (cnt == '0);

  assign load_use = hz.ex_memread && (hz.ex_rt != '0) &&
                    ((hz.id_use_rs && (hz.id_rs == hz.ex_rt)) ||
                     (hz.id_use_rt && (hz.id_rt == hz.ex_rt)));

  assign md_stall = busy && !done && (hz.id_md || hz.id_mfhilo);

  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_clear = 1'b0;
    idex_hold  = 1'b0;
    idex_clear = 1'b0;
    exmem_hold = 1'b0;
    memwb_hold = 1'b0;
    if (hz.mem_wait) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
      memwb_hold = 1'b1;
    end else if (hz.ex_br_taken) begin
      ifid_clear = 1'b1;
      idex_clear = 1'b1;
    end else if (load_use || md_stall) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_clear = 1'b1;
    end
  end

  assign hz.pc_hold     = pc_hold;
  assign hz.ifid_hold   = ifid_hold;
  assign hz.ifid_clear  = ifid_clear;
  assign hz.idex_hold   = idex_hold;
  assign hz.idex_clear  = idex_clear;
  assign hz.exmem_hold  = exmem_hold;
  assign hz.exmem_clear = 1'b0;
  assign hz.memwb_hold  = memwb_hold;
  assign hz.memwb_clear = 1'b0;
  assign hz.md_busy     = busy;
  assign hz.md_done     = done;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: fixed vector table, directed mult/div/reset
// sequences and randomized cycles against a remaining-cycles reference model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  localparam logic [8:0] C_NONE  = 9'b000000000;
  localparam logic [8:0] C_STALL = 9'b110010000;
  localparam logic [8:0] C_BR    = 9'b001010000;
  localparam logic [8:0] C_MW    = 9'b110101010;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   rem;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, mfhilo, memread;
    logic [4:0] ex_rt;
    logic       br, mw;
    logic [8:0] exp_ctl;
  } vec_t;

  function automatic logic [8:0] ref_ctl(input bit busy, input bit done);
    bit lu, mds;
    lu  = hz.ex_memread && hz.ex_rt != 0 &&
          ((hz.id_use_rs && hz.id_rs == hz.ex_rt) || (hz.id_use_rt && hz.id_rt == hz.ex_rt));
    mds = busy && !done && (hz.id_md || hz.id_mfhilo);
    if (hz.mem_wait)          return C_MW;
    else if (hz.ex_br_taken)  return C_BR;
    else if (lu || mds)       return C_STALL;
    else                      return C_NONE;
  endfunction

  function automatic logic [10:0] dut_out();
    return {hz.pc_hold, hz.ifid_hold, hz.ifid_clear, hz.idex_hold, hz.idex_clear,
            hz.exmem_hold, hz.exmem_clear, hz.memwb_hold, hz.memwb_clear,
            hz.md_busy, hz.md_done};
  endfunction

  task automatic check_model(input string name);
    logic [10:0] exp, act;
    #1;
    exp = {ref_ctl(rem > 0, rem == 1), rem > 0, rem == 1};
    act = dut_out();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: rem = cycles of occupancy still ahead, including the current one.
  task automatic tick();
    @(posedge clk);
    if (!rst_n)                rem = 0;
    else if (rem > 0)          rem = rem - 1;
    else if (hz.ex_md_start)   rem = hz.ex_md_div ? DIV_N : MUL_N;
    #1;
  endtask

  task automatic drive_idle();
    hz.id_rs = '0; hz.id_rt = '0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.id_md = 0; hz.id_mfhilo = 0; hz.ex_memread = 0; hz.ex_rt = '0;
    hz.ex_md_start = 0; hz.ex_md_div = 0; hz.ex_br_taken = 0; hz.mem_wait = 0;
  endtask

  task automatic start_md(input logic div, input string name);
    hz.ex_md_start = 1; hz.ex_md_div = div;
    check_model(name);
    tick();
    hz.ex_md_start = 0;
  endtask

  vec_t vecs[11];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rem      = 0;
    rst_n    = 0;
    drive_idle();

    vecs[0]  = '{5'd8,  5'd0,  1,0,0,1, 5'd8,  0,0, C_STALL};
    vecs[1]  = '{5'd0,  5'd0,  1,0,0,1, 5'd0,  0,0, C_NONE};
    vecs[2]  = '{5'd3,  5'd9,  0,1,0,1, 5'd9,  0,0, C_STALL};
    vecs[3]  = '{5'd8,  5'd0,  0,1,0,1, 5'd8,  0,0, C_NONE};
    vecs[4]  = '{5'd8,  5'd0,  1,0,0,0, 5'd8,  0,0, C_NONE};
    vecs[5]  = '{5'd8,  5'd0,  1,0,0,1, 5'd8,  1,0, C_BR};
    vecs[6]  = '{5'd8,  5'd0,  1,0,0,1, 5'd8,  1,1, C_MW};
    vecs[7]  = '{5'd0,  5'd0,  0,0,0,0, 5'd0,  1,0, C_BR};
    vecs[8]  = '{5'd0,  5'd0,  0,0,0,0, 5'd0,  0,1, C_MW};
    vecs[9]  = '{5'd0,  5'd0,  0,0,1,0, 5'd0,  0,0, C_NONE};
    vecs[10] = '{5'd1,  5'd31, 1,1,0,1, 5'd31, 0,0, C_STALL};

    // Reset state, and freeze outputs still honoured under reset
    #2;
    n_checks++;
    if (dut_out() !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", dut_out(), 11'b0);
    end
    hz.mem_wait = 1;
    check_model("reset_memwait");
    hz.mem_wait = 0;
    @(posedge clk);
    #1 rst_n = 1;

    for (int i = 0; i < 11; i++) begin
      tick();
      drive_idle();
      hz.id_rs = vecs[i].rs; hz.id_rt = vecs[i].rt;
      hz.id_use_rs = vecs[i].use_rs; hz.id_use_rt = vecs[i].use_rt;
      hz.id_mfhilo = vecs[i].mfhilo; hz.ex_memread = vecs[i].memread;
      hz.ex_rt = vecs[i].ex_rt; hz.ex_br_taken = vecs[i].br; hz.mem_wait = vecs[i].mw;
      #1;
      n_checks++;
      if (dut_out() !== {vecs[i].exp_ctl, 2'b00}) begin
        n_fail++;
        $display("FAIL vec%0d: got %b expected %b", i, dut_out(), {vecs[i].exp_ctl, 2'b00});
      end
    end

    // Multiply with mfhi waiting in ID: stalled cycles 1-3, released on 4
    tick(); drive_idle();
    hz.id_mfhilo = 1;
    start_md(0, "mul_start");
    for (int k = 1; k <= 4; k++) begin
      check_model($sformatf("mul_c%0d", k));
      chk_bit($sformatf("mul_busy_c%0d", k), hz.md_busy, 1'b1);
      chk_bit($sformatf("mul_done_c%0d", k), hz.md_done, k == 4);
      chk_bit($sformatf("mul_stall_c%0d", k), hz.pc_hold, k < 4);
      tick();
    end
    check_model("mul_after");
    chk_bit("mul_after_busy", hz.md_busy, 1'b0);

    // Second start at busy cycle 2 is dropped
    tick(); drive_idle();
    start_md(0, "ign_start");
    for (int k = 1; k <= 5; k++) begin
      hz.ex_md_start = (k == 2);
      check_model($sformatf("ign_c%0d", k));
      chk_bit($sformatf("ign_done_c%0d", k), hz.md_done, k == 4);
      chk_bit($sformatf("ign_busy_c%0d", k), hz.md_busy, k <= 4);
      tick();
    end
    hz.ex_md_start = 0;

    // Memory wait with branch and load-use: freeze wins, counter still runs
    drive_idle();
    start_md(0, "mw_start");
    hz.mem_wait = 1; hz.ex_br_taken = 1;
    hz.ex_memread = 1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1;
    for (int k = 1; k <= 4; k++) begin
      check_model($sformatf("mw_c%0d", k));
      chk_bit($sformatf("mw_done_c%0d", k), hz.md_done, k == 4);
      tick();
    end
    check_model("mw_after");

    // Divide aborted by asynchronous reset at busy cycle 10
    drive_idle();
    start_md(1, "div_start");
    for (int k = 1; k <= 10; k++) begin
      check_model($sformatf("div_c%0d", k));
      if (k < 10) tick();
    end
    rst_n = 0;
    rem   = 0;
    check_model("div_rst");
    chk_bit("div_rst_busy", hz.md_busy, 1'b0);
    tick();
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      check_model($sformatf("post_rst_%0d", k));
      tick();
    end

    // Randomized cycles against the model
    for (int n = 0; n < 3000; n++) begin
      hz.id_rs       = 5'($urandom_range(0, 3));
      hz.id_rt       = 5'($urandom_range(0, 3));
      hz.ex_rt       = 5'($urandom_range(0, 3));
      hz.id_use_rs   = 1'($urandom);
      hz.id_use_rt   = 1'($urandom);
      hz.id_md       = ($urandom_range(0, 3) == 0);
      hz.id_mfhilo   = ($urandom_range(0, 3) == 0);
      hz.ex_memread  = 1'($urandom);
      hz.ex_md_start = ($urandom_range(0, 7) == 0);
      hz.ex_md_div   = 1'($urandom);
      hz.ex_br_taken = ($urandom_range(0, 5) == 0);
      hz.mem_wait    = ($urandom_range(0, 5) == 0);
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 199) == 0) begin
        rst_n = 0;
        rem   = 0;
      end
      check_model($sformatf("rand_%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
